// File: rtl/ram_pkg.sv
// Shared types and default parameter values for the ram_ctrl slice.
package ram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int          DEF_DATA_W      = 16;
    localparam int          DEF_ADDR_W      = 16;
    localparam int          DEF_WAIT_CYCLES = 2;
    localparam logic [15:0] DEF_PROT_LIMIT  = 16'h3000;

endpackage

// File: rtl/ram_ctrl_if.sv
// Request/response bundle between a bus master and the ram_ctrl slave.
interface ram_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              en;
    logic              wEn;
    logic [DATA_W-1:0] dataIn;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dataOut;
    logic              R;
    logic              busy;
    logic              fault;

    modport master (output en, wEn, dataIn, addr, input dataOut, R, busy, fault);
    modport slave  (input en, wEn, dataIn, addr, output dataOut, R, busy, fault);
endinterface

// File: rtl/ram_array.sv
// Single-port storage: synchronous write, registered read, contents never reset.
module ram_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/ram_ctrl.sv
// Wait-state RAM access controller (IDLE -> WAIT -> DONE).
// Define RAM_WPROT_EN to drop writes below PROT_LIMIT and pulse fault with R.
module ram_ctrl
    import ram_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter logic [ADDR_W-1:0] PROT_LIMIT  = ADDR_W'(DEF_PROT_LIMIT)
) (
    input logic        clk,
    input logic        reset,
    ram_ctrl_if.slave  bus
);
`ifdef RAM_WPROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              wen_q;
    logic              rd_valid_q;
    logic              fault_q;
    logic              latch_en;
    logic              go_done;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_din;
    logic              op_wen;
    logic              wr_block;
    logic              arr_we, arr_re;
    logic [DATA_W-1:0] rdata;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        go_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.en) begin
                    latch_en = 1'b1;
                    cnt_d    = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d = DONE;
                        go_done = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                    go_done = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states the access happens on the accepting edge, so use the live operands.
    assign op_addr  = (state_q == IDLE) ? bus.addr   : addr_q;
    assign op_din   = (state_q == IDLE) ? bus.dataIn : din_q;
    assign op_wen   = (state_q == IDLE) ? bus.wEn    : wen_q;
    assign wr_block = PROT_EN && (op_addr < PROT_LIMIT);
    assign arr_we   = go_done && !reset && op_wen && !wr_block;
    assign arr_re   = go_done && !reset && !op_wen;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= go_done && op_wen && wr_block;
            if (arr_re) rd_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (latch_en && !reset) begin
            addr_q <= bus.addr;
            din_q  <= bus.dataIn;
            wen_q  <= bus.wEn;
        end
    end

    ram_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (op_addr),
        .wdata_i (op_din),
        .rdata_o (rdata)
    );

    // Array output register has no reset; mask it until the first completed read.
    assign bus.dataOut = rd_valid_q ? rdata : '0;
    assign bus.R       = (state_q == DONE);
    assign bus.busy    = (state_q != IDLE);
    assign bus.fault   = fault_q;
endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: two instances, WAIT_CYCLES=2 (A) and WAIT_CYCLES=0 (B).
module tb_ram_ctrl;
`ifdef RAM_WPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ram_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus_a ();
    ram_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus_b ();

    ram_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(2), .PROT_LIMIT(16'h3000)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    ram_ctrl #(.DATA_W(16), .ADDR_W(16), .WAIT_CYCLES(0), .PROT_LIMIT(16'h3000)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit b, input logic e, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        if (!b) begin
            bus_a.en = e; bus_a.wEn = w; bus_a.addr = a; bus_a.dataIn = d;
        end else begin
            bus_b.en = e; bus_b.wEn = w; bus_b.addr = a; bus_b.dataIn = d;
        end
    endtask

    function automatic logic r_of(input bit b);
        return b ? bus_b.R : bus_a.R;
    endfunction
    function automatic logic busy_of(input bit b);
        return b ? bus_b.busy : bus_a.busy;
    endfunction
    function automatic logic fault_of(input bit b);
        return b ? bus_b.fault : bus_a.fault;
    endfunction
    function automatic logic [15:0] dout_of(input bit b);
        return b ? bus_b.dataOut : bus_a.dataOut;
    endfunction

    // One access; lat counts edges from the accepting edge to the first edge showing R.
    task automatic access(input bit b, input logic w, input logic [15:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] dout, output logic flt,
                          output logic busy_ok);
        @(negedge clk);
        drive(b, 1'b1, w, a, d);
        @(posedge clk); #1;
        drive(b, 1'b0, 1'b0, 16'h0, 16'h0);
        lat = 1;
        busy_ok = 1'b1;
        while (!r_of(b) && lat < 20) begin
            busy_ok &= busy_of(b);
            @(posedge clk); #1;
            lat++;
        end
        busy_ok &= busy_of(b);
        dout = dout_of(b);
        flt  = fault_of(b);
        @(posedge clk); #1;
    endtask

    initial begin
        int          lat;
        int          r_cnt;
        logic [15:0] dout;
        logic [15:0] v0;
        logic [15:0] d_at_r;
        logic        flt;
        logic        bok;
        logic [6:0]  pat;

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_R",     32'(bus_a.R),       32'h0);
        check("rst_busy",  32'(bus_a.busy),    32'h0);
        check("rst_fault", 32'(bus_a.fault),   32'h0);
        check("rst_dout",  32'(bus_a.dataOut), 32'h0);
        check("rst_dout_b", 32'(bus_b.dataOut), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Basic write/read with two wait states
        access(0, 1'b1, 16'h4000, 16'hBEEF, lat, dout, flt, bok);
        check("wr4000_lat",  32'(lat), 32'd3);
        check("wr4000_busy", 32'(bok), 32'h1);
        access(0, 1'b0, 16'h4000, 16'h0, lat, dout, flt, bok);
        check("rd4000_lat",  32'(lat),  32'd3);
        check("rd4000_data", 32'(dout), 32'hBEEF);

        // A write leaves dataOut alone
        access(0, 1'b1, 16'h0010, 16'h5555, lat, dout, flt, bok);
        check("wr_hold_dout", 32'(bus_a.dataOut), 32'hBEEF);
        access(0, 1'b0, 16'h0010, 16'h0, lat, dout, flt, bok);
        check("rd0010_data", 32'(dout), 32'h5555);

        // Inputs toggled during WAIT are ignored
        access(0, 1'b1, 16'h0020, 16'h1111, lat, dout, flt, bok);
        access(0, 1'b1, 16'h0021, 16'h2222, lat, dout, flt, bok);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 16'h0020, 16'h0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 16'h0021, 16'hDEAD);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 16'h0022, 16'h0);
        r_cnt  = 0;
        d_at_r = 16'h0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus_a.R) begin
                r_cnt++;
                d_at_r = bus_a.dataOut;
            end
        end
        check("toggle_rcount", 32'(r_cnt),  32'd1);
        check("toggle_data",   32'(d_at_r), 32'h1111);
        access(0, 1'b0, 16'h0021, 16'h0, lat, dout, flt, bok);
        check("toggle_nowr", 32'(dout), 32'h2222);

        // Reset during WAIT aborts a write
        access(0, 1'b1, 16'h5000, 16'h7777, lat, dout, flt, bok);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 16'h5000, 16'h1234);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        check("abort_busy_wait", 32'(bus_a.busy), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("abort_busy",  32'(bus_a.busy),    32'h0);
        check("abort_dout0", 32'(bus_a.dataOut), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        r_cnt = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus_a.R) r_cnt++;
        end
        check("abort_noR", 32'(r_cnt), 32'd0);
        access(0, 1'b0, 16'h5000, 16'h0, lat, dout, flt, bok);
        check("abort_prior", 32'(dout), 32'h7777);

        // Reset wins over en in the same cycle
        @(negedge clk);
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 16'h4000, 16'h0);
        @(posedge clk); #1;
        check("rst_prio_busy", 32'(bus_a.busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk); #1;
        check("rst_prio_idle", 32'(bus_a.busy), 32'h0);

        // Write protection boundary
        access(0, 1'b0, 16'h0200, 16'h0, lat, v0, flt, bok);
        access(0, 1'b1, 16'h0200, 16'hAAAA, lat, dout, flt, bok);
        check("prot_lat",   32'(lat), 32'd3);
        check("prot_fault", 32'(flt), 32'(PROT));
        access(0, 1'b0, 16'h0200, 16'h0, lat, dout, flt, bok);
        check("prot_data", 32'(dout), PROT ? 32'(v0) : 32'hAAAA);
        access(0, 1'b1, 16'h3000, 16'hCAFE, lat, dout, flt, bok);
        check("lim_fault", 32'(flt), 32'h0);
        access(0, 1'b0, 16'h3000, 16'h0, lat, dout, flt, bok);
        check("lim_data", 32'(dout), 32'hCAFE);
        check("rd_fault", 32'(flt), 32'h0);

        // Top address
        access(0, 1'b1, 16'hFFFF, 16'h0F0F, lat, dout, flt, bok);
        check("ffff_wr_lat",  32'(lat), 32'd3);
        check("ffff_wr_busy", 32'(bok), 32'h1);
        check("ffff_idle",    32'(bus_a.busy), 32'h0);
        access(0, 1'b0, 16'hFFFF, 16'h0, lat, dout, flt, bok);
        check("ffff_rd_busy", 32'(bok),  32'h1);
        check("ffff_data",    32'(dout), 32'h0F0F);

        // Zero wait states
        access(1, 1'b1, 16'h0005, 16'h0ABC, lat, dout, flt, bok);
        check("w0_wr_lat", 32'(lat), 32'd1);
        access(1, 1'b0, 16'h0005, 16'h0, lat, dout, flt, bok);
        check("w0_rd_lat",  32'(lat),  32'd1);
        check("w0_rd_data", 32'(dout), 32'h0ABC);
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 16'h0005, 16'h0);
        pat = '0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            pat = {pat[5:0], bus_b.R};
            if (i == 4) drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        end
        check("w0_stream_pat",  32'(pat), 32'b1010100);
        check("w0_stream_data", 32'(bus_b.dataOut), 32'h0ABC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
